// File: rtl/approx_blk_adder_pipe_if.sv
// Operand/result stream bundle for the approximate block adder pipeline.
// master drives operands and out_ready; slave is the adder.
interface approx_blk_adder_pipe_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             grp_p;
  logic             grp_g;
  logic             err;

  modport master (
    output in_valid, a, b, ci, mode, out_ready,
    input  in_ready, out_valid, sum, cout, grp_p, grp_g, err
  );

  modport slave (
    input  in_valid, a, b, ci, mode, out_ready,
    output in_ready, out_valid, sum, cout, grp_p, grp_g, err
  );
endinterface

// File: rtl/approx_blk_adder_pipe.sv
// Two-stage carry-select block adder with exact or windowed-speculation carries.
// Stage 1 captures per-block P/G and both local sums; stage 2 resolves carries.
module approx_blk_adder_pipe #(
  parameter int BLK      = 3,
  parameter int NBLK     = 4,
  parameter int LOOKBACK = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  approx_blk_adder_pipe_if.slave bus
);
  localparam int WIDTH = BLK * NBLK;

  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_adv;
  logic s2_adv;
  logic accept;

  logic [NBLK-1:0]  p_reg,    p_next;
  logic [NBLK-1:0]  g_reg,    g_next;
  logic [WIDTH-1:0] sum0_reg, sum0_next;
  logic [WIDTH-1:0] sum1_reg, sum1_next;
  logic             ci_reg;
  logic             mode_reg;

  logic [WIDTH-1:0] sum_reg,   sum_next;
  logic             cout_reg,  cout_next;
  logic             grp_p_reg, grp_p_next;
  logic             grp_g_reg, grp_g_next;
  logic             err_reg,   err_next;

  // in_ready depends only on stage state and out_ready, never on in_valid.
  assign s2_adv       = !s2_valid_reg || bus.out_ready;
  assign s1_adv       = s1_valid_reg && s2_adv;
  assign bus.in_ready = !s1_valid_reg || s1_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_block
      logic [BLK:0]   raw0;
      logic [BLK-1:0] raw1;
      assign raw0 = {1'b0, bus.a[gi*BLK +: BLK]} + {1'b0, bus.b[gi*BLK +: BLK]};
      assign raw1 = raw0[BLK-1:0] + BLK'(1);
      assign p_next[gi]                = &(bus.a[gi*BLK +: BLK] ^ bus.b[gi*BLK +: BLK]);
      assign g_next[gi]                = raw0[BLK];
      assign sum0_next[gi*BLK +: BLK]  = raw0[BLK-1:0];
      assign sum1_next[gi*BLK +: BLK]  = raw1;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      p_reg        <= '0;
      g_reg        <= '0;
      sum0_reg     <= '0;
      sum1_reg     <= '0;
      ci_reg       <= 1'b0;
      mode_reg     <= 1'b0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      p_reg        <= p_next;
      g_reg        <= g_next;
      sum0_reg     <= sum0_next;
      sum1_reg     <= sum1_next;
      ci_reg       <= bus.ci;
      mode_reg     <= bus.mode;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  logic [NBLK:0] c_ex;
  logic [NBLK:0] c_ap;
  logic [NBLK:0] c_sel;
  logic [NBLK:0] c_gen;

  // Exact lookahead from ci, plus the ci=0 chain that yields the group generate.
  always_comb begin
    c_ex     = '0;
    c_gen    = '0;
    c_ex[0]  = ci_reg;
    c_gen[0] = 1'b0;
    for (int k = 0; k < NBLK; k++) begin
      c_ex[k+1]  = g_reg[k] | (p_reg[k] & c_ex[k]);
      c_gen[k+1] = g_reg[k] | (p_reg[k] & c_gen[k]);
    end
  end

  assign c_ap[0] = ci_reg;

  // Each speculative carry only looks LOOKBACK blocks down; seed is 0 unless the window reaches block 0.
  generate
    for (genvar gi = 1; gi <= NBLK; gi++) begin : g_spec
      localparam int J0 = (gi > LOOKBACK) ? gi - LOOKBACK : 0;
      logic c_run;
      always_comb begin
        c_run = (J0 == 0) ? ci_reg : 1'b0;
        for (int j = J0; j < gi; j++) begin
          c_run = g_reg[j] | (p_reg[j] & c_run);
        end
      end
      assign c_ap[gi] = c_run;
    end
  endgenerate

  assign c_sel = mode_reg ? c_ap : c_ex;

  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_select
      assign sum_next[gi*BLK +: BLK] = c_sel[gi] ? sum1_reg[gi*BLK +: BLK]
                                                 : sum0_reg[gi*BLK +: BLK];
    end
  endgenerate

  assign cout_next  = c_sel[NBLK];
  assign grp_p_next = &p_reg;
  assign grp_g_next = c_gen[NBLK];
  assign err_next   = mode_reg && (c_ap[NBLK:1] != c_ex[NBLK:1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      sum_reg      <= '0;
      cout_reg     <= 1'b0;
      grp_p_reg    <= 1'b0;
      grp_g_reg    <= 1'b0;
      err_reg      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg   <= sum_next;
        cout_reg  <= cout_next;
        grp_p_reg <= grp_p_next;
        grp_g_reg <= grp_g_next;
        err_reg   <= err_next;
      end
    end
  end

  assign bus.out_valid = s2_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.grp_p     = grp_p_reg;
  assign bus.grp_g     = grp_g_reg;
  assign bus.err       = err_reg;
endmodule
